// File: rtl/gpio_debounce_evt.sv
// GPIO debouncer with edge-event reporting.
// Each enabled input bit is filtered by a run-length counter; debounced
// edges are collected into a one-deep event word with a valid/ready
// handshake, a pending set for edges that arrive while the word is held,
// an overflow flag for lost edges and a rolling sequence number.
module gpio_debounce_evt #(
  parameter int                        GPIO_REG_WIDTH  = 12,
  parameter int                        DEBOUNCE_CYCLES = 16,
  parameter logic [GPIO_REG_WIDTH-1:0] IN_MASK         = 12'h022,
  parameter int                        SEQ_WIDTH       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [GPIO_REG_WIDTH-1:0] gpio_in_i,
  input  logic [GPIO_REG_WIDTH-1:0] rise_en_i,
  input  logic [GPIO_REG_WIDTH-1:0] fall_en_i,
  output logic [GPIO_REG_WIDTH-1:0] stable_o,
  output logic                      evt_valid_o,
  input  logic                      evt_ready_i,
  output logic [GPIO_REG_WIDTH-1:0] evt_rise_o,
  output logic [GPIO_REG_WIDTH-1:0] evt_fall_o,
  output logic [GPIO_REG_WIDTH-1:0] evt_level_o,
  output logic                      evt_overflow_o,
  output logic [SEQ_WIDTH-1:0]      evt_seq_o
);

  localparam int W = GPIO_REG_WIDTH;
  // Counter value seen on the edge before the flipping sample; the
  // DEBOUNCE_CYCLES-th differing sample flips the level instead of counting.
  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = {{(SEQ_WIDTH-1){1'b0}}, 1'b1};

  logic [W-1:0][15:0] cnt_q, cnt_d;
  logic [W-1:0]       stable_q, stable_d;
  logic [W-1:0]       hist_q;
  logic [W-1:0]       pend_rise_q, pend_rise_d;
  logic [W-1:0]       pend_fall_q, pend_fall_d;
  logic               pend_ovf_q, pend_ovf_d;
  logic               evt_valid_q, evt_valid_d;
  logic [W-1:0]       evt_rise_q, evt_rise_d;
  logic [W-1:0]       evt_fall_q, evt_fall_d;
  logic [W-1:0]       evt_level_q, evt_level_d;
  logic               evt_ovf_q, evt_ovf_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic               first_q, first_d;

  logic [W-1:0] q_rise, q_fall;
  logic [W-1:0] un_rise, un_fall;
  logic         out_free, load;

  // Per-bit run-length debounce; masked-off bits are pinned to zero.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    for (int i = 0; i < W; i++) begin
      if (!IN_MASK[i]) begin
        cnt_d[i]    = '0;
        stable_d[i] = 1'b0;
      end else if (gpio_in_i[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        cnt_d[i]    = '0;
        stable_d[i] = ~stable_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Qualified edges this cycle, and the union that would be loaded.
  assign q_rise   = stable_q & ~hist_q & rise_en_i & IN_MASK;
  assign q_fall   = ~stable_q & hist_q & fall_en_i & IN_MASK;
  assign un_rise  = pend_rise_q | q_rise;
  assign un_fall  = pend_fall_q | q_fall;
  assign out_free = !evt_valid_q || evt_ready_i;
  assign load     = out_free && ((|un_rise) || (|un_fall));

  // Event word load / drain and pending-set accumulation.
  always_comb begin
    pend_rise_d = pend_rise_q;
    pend_fall_d = pend_fall_q;
    pend_ovf_d  = pend_ovf_q;
    evt_valid_d = evt_valid_q;
    evt_rise_d  = evt_rise_q;
    evt_fall_d  = evt_fall_q;
    evt_level_d = evt_level_q;
    evt_ovf_d   = evt_ovf_q;
    seq_d       = seq_q;
    first_d     = first_q;
    if (load) begin
      evt_valid_d = 1'b1;
      evt_rise_d  = un_rise;
      evt_fall_d  = un_fall;
      evt_level_d = stable_q;
      evt_ovf_d   = pend_ovf_q;
      pend_rise_d = '0;
      pend_fall_d = '0;
      pend_ovf_d  = 1'b0;
      // The very first word after reset keeps sequence number zero.
      if (first_q) seq_d = seq_q + SEQ_ONE;
      first_d = 1'b1;
    end else begin
      if (out_free) evt_valid_d = 1'b0;
      // A repeat of an edge already waiting means an edge is lost.
      if ((|(pend_rise_q & q_rise)) || (|(pend_fall_q & q_fall))) pend_ovf_d = 1'b1;
      pend_rise_d = un_rise;
      pend_fall_d = un_fall;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      stable_q    <= '0;
      hist_q      <= '0;
      pend_rise_q <= '0;
      pend_fall_q <= '0;
      pend_ovf_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_rise_q  <= '0;
      evt_fall_q  <= '0;
      evt_level_q <= '0;
      evt_ovf_q   <= 1'b0;
      seq_q       <= '0;
      first_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      hist_q      <= stable_q;
      pend_rise_q <= pend_rise_d;
      pend_fall_q <= pend_fall_d;
      pend_ovf_q  <= pend_ovf_d;
      evt_valid_q <= evt_valid_d;
      evt_rise_q  <= evt_rise_d;
      evt_fall_q  <= evt_fall_d;
      evt_level_q <= evt_level_d;
      evt_ovf_q   <= evt_ovf_d;
      seq_q       <= seq_d;
      first_q     <= first_d;
    end
  end

  assign stable_o       = stable_q;
  assign evt_valid_o    = evt_valid_q;
  assign evt_rise_o     = evt_rise_q;
  assign evt_fall_o     = evt_fall_q;
  assign evt_level_o    = evt_level_q;
  assign evt_overflow_o = evt_ovf_q;
  assign evt_seq_o      = seq_q;

endmodule

// File: tb/tb_gpio_debounce_evt.sv
// Bench for gpio_debounce_evt: directed scenarios followed by a random
// phase, all outputs compared every cycle against a behavioural model.
module tb_gpio_debounce_evt;
  localparam int W = 12, D = 4, SW = 8;
  localparam logic [W-1:0] MASK = 12'h022;

  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b0;
  logic [W-1:0] gpio = '0, ren = '1, fen = '1;
  logic [W-1:0] stable, e_rise, e_fall, e_lvl;
  logic e_valid, e_ovf;
  logic [SW-1:0] e_seq;

  int vectors = 0, miscompares = 0;

  // behavioural model state
  bit [W-1:0] m_st, m_prev, m_pr, m_pf, m_r, m_f, m_lvl;
  bit m_po, m_v, m_o, m_seen;
  int m_seq;
  int run[W];

  gpio_debounce_evt #(.GPIO_REG_WIDTH(W), .DEBOUNCE_CYCLES(D), .IN_MASK(MASK), .SEQ_WIDTH(SW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .gpio_in_i(gpio), .rise_en_i(ren), .fall_en_i(fen),
    .stable_o(stable), .evt_valid_o(e_valid), .evt_ready_i(rdy), .evt_rise_o(e_rise),
    .evt_fall_o(e_fall), .evt_level_o(e_lvl), .evt_overflow_o(e_ovf), .evt_seq_o(e_seq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = '0; m_prev = '0; m_pr = '0; m_pf = '0; m_po = 0;
    m_v = 0; m_r = '0; m_f = '0; m_lvl = '0; m_o = 0; m_seq = 0; m_seen = 0;
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  // One clock edge of the reference behaviour, from the rules directly.
  task automatic m_edge();
    bit [W-1:0] qr, qf;
    bit free;
    if (!rst_n) begin m_reset(); return; end
    qr = m_st & ~m_prev & ren & MASK;
    qf = ~m_st & m_prev & fen & MASK;
    free = !m_v || rdy;
    if (free && (((m_pr | qr) != 0) || ((m_pf | qf) != 0))) begin
      m_r = m_pr | qr; m_f = m_pf | qf; m_lvl = m_st; m_o = m_po; m_v = 1;
      m_seq = m_seen ? (m_seq + 1) % (1 << SW) : 0;
      m_seen = 1;
      m_pr = '0; m_pf = '0; m_po = 0;
    end else begin
      if (free) m_v = 0;
      if (((m_pr & qr) | (m_pf & qf)) != 0) m_po = 1;
      m_pr |= qr; m_pf |= qf;
    end
    m_prev = m_st;
    for (int i = 0; i < W; i++) begin
      if (!MASK[i]) continue;
      if (gpio[i] != m_st[i]) begin
        run[i]++;
        if (run[i] >= D) begin m_st[i] = ~m_st[i]; run[i] = 0; end
      end else run[i] = 0;
    end
  endtask

  task automatic check_all();
    chk("stable", 32'(stable), 32'(m_st));
    chk("evt_valid", 32'(e_valid), 32'(m_v));
    chk("evt_rise", 32'(e_rise), 32'(m_r));
    chk("evt_fall", 32'(e_fall), 32'(m_f));
    chk("evt_level", 32'(e_lvl), 32'(m_lvl));
    chk("evt_overflow", 32'(e_ovf), 32'(m_o));
    chk("evt_seq", 32'(e_seq), 32'(m_seq));
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      m_edge();
      #1;
      check_all();
    end
  endtask

  initial begin
    m_reset();
    // reset held: toggling inputs has no effect
    for (int k = 0; k < 6; k++) begin
      gpio = (k % 2 == 0) ? '1 : '0;
      tick(1);
      chk("rst_stable", 32'(stable), 32'h0);
      chk("rst_valid", 32'(e_valid), 32'h0);
    end
    gpio = '0; rst_n = 1'b1;
    tick(2);

    // single debounced rise on bit 1
    rdy = 1'b1; gpio[1] = 1'b1;
    tick(3);
    chk("rise_before_4th", 32'(stable), 32'h0);
    tick(1);
    chk("rise_stable", 32'(stable), 32'h002);
    tick(1);
    chk("rise_valid", 32'(e_valid), 32'h1);
    chk("rise_bitmap", 32'(e_rise), 32'h002);
    chk("rise_level", 32'(e_lvl), 32'h002);
    chk("rise_seq", 32'(e_seq), 32'h0);
    tick(1);
    chk("rise_drop", 32'(e_valid), 32'h0);

    // short glitch on bit 5 and unmasked bit 0 toggling: nothing happens
    gpio[5] = 1'b1;
    tick(3);
    gpio[5] = 1'b0;
    for (int k = 0; k < 6; k++) begin gpio[0] = ~gpio[0]; tick(1); end
    chk("glitch_stable", 32'(stable), 32'h002);
    chk("glitch_valid", 32'(e_valid), 32'h0);
    gpio[0] = 1'b0;

    // bit 1 back low, drained immediately
    gpio[1] = 1'b0;
    tick(6);
    // held word while edges pile up and one repeats
    rdy = 1'b0; gpio[1] = 1'b1;
    tick(5);
    chk("hold_valid", 32'(e_valid), 32'h1);
    gpio[1] = 1'b0; tick(5);
    chk("hold_rise", 32'(e_rise), 32'h002);
    chk("hold_fall", 32'(e_fall), 32'h0);
    gpio[1] = 1'b1; tick(5);
    gpio[1] = 1'b0; tick(5);
    rdy = 1'b1;
    tick(1);
    chk("ovf_rise", 32'(e_rise), 32'h002);
    chk("ovf_fall", 32'(e_fall), 32'h002);
    chk("ovf_flag", 32'(e_ovf), 32'h1);
    tick(2);

    // rise disabled: only the fall of bit 5 is reported
    ren = '0; gpio[5] = 1'b1;
    tick(6);
    chk("norise_valid", 32'(e_valid), 32'h0);
    gpio[5] = 1'b0;
    tick(5);
    chk("fall_valid", 32'(e_valid), 32'h1);
    chk("fall_bitmap", 32'(e_fall), 32'h020);
    chk("fall_norise", 32'(e_rise), 32'h0);
    tick(1);
    ren = '1;

    // reset mid-handshake and mid-debounce
    rdy = 1'b0; gpio[1] = 1'b1;
    tick(5);
    gpio[5] = 1'b1;
    tick(2);
    #2 rst_n = 1'b0;
    #1 m_reset();
    check_all();
    chk("async_valid", 32'(e_valid), 32'h0);
    tick(2);
    rst_n = 1'b1; rdy = 1'b1;
    tick(3);
    chk("post_rst_early", 32'(stable), 32'h0);
    tick(1);
    chk("post_rst_stable", 32'(stable), 32'h022);
    tick(1);
    chk("post_rst_valid", 32'(e_valid), 32'h1);
    chk("post_rst_seq", 32'(e_seq), 32'h0);
    tick(2);

    // random phase
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) gpio = gpio ^ 12'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      if (k % 50 == 0) begin ren = 12'($urandom); fen = 12'($urandom); end
      rst_n = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
